// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : life_pkg
//  Description : Shared constants, types and width helpers for the
//                Generations-family cellular automaton cell.
//  Revision    : 1.0 - initial release
// ============================================================================
package life_pkg;

    // Well-known cell states
    localparam int ST_DEAD  = 0;
    localparam int ST_ALIVE = 1;

    // Default-width cell state type (matches the default STATE_W of the cell)
    localparam int LIFE_STATE_W = 4;
    typedef logic [LIFE_STATE_W-1:0] cell_state_t;

    // Classic Conway Life rule masks for a Moore (8-neighbour) cell: B3/S23
    localparam logic [8:0] LIFE_BIRTH_CLASSIC   = 9'b0_0000_1000;
    localparam logic [8:0] LIFE_SURVIVE_CLASSIC = 9'b0_0000_1100;

    // Width needed to hold a population count of n bits (0..n)
    function automatic int CNT_W(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_n.sv
`default_nettype none
// ============================================================================
//  Module      : adder_n
//  Description : W-bit ripple-carry adder, carry-out discarded (callers size
//                W so the sum never overflows).
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_n #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);

    // Bit-serial ripple of the carry from LSB to MSB
    always_comb begin
        logic w_carry;
        w_carry = 1'b0;
        o_sum   = '0;
        for (int i = 0; i < W; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
            w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
        end
    end

endmodule
`default_nettype wire

// File: rtl/neighbor_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : neighbor_popcount
//  Description : Population count of N alive bits, built as a recursive
//                binary tree of adder_n ripple adders.
//  Revision    : 1.0 - initial release
// ============================================================================
module neighbor_popcount
    import life_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]          i_bits,
    output logic [CNT_W(N)-1:0]   o_count
);

    localparam int c_W   = CNT_W(N);
    localparam int c_NLO = N / 2;
    localparam int c_NHI = N - (N / 2);

    generate
        if (N == 1) begin : g_leaf
            assign o_count = i_bits;
        end else begin : g_tree
            logic [CNT_W(c_NLO)-1:0] w_lo;
            logic [CNT_W(c_NHI)-1:0] w_hi;

            neighbor_popcount #(.N(c_NLO)) u_lo (
                .i_bits  (i_bits[c_NLO-1:0]),
                .o_count (w_lo)
            );

            neighbor_popcount #(.N(c_NHI)) u_hi (
                .i_bits  (i_bits[N-1:c_NLO]),
                .o_count (w_hi)
            );

            // Both halves zero-extended to the full width; sum <= N always fits
            adder_n #(.W(c_W)) u_add (
                .i_a   (c_W'(w_lo)),
                .i_b   (c_W'(w_hi)),
                .o_sum (o_count)
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/life_cell_gen.sv
`default_nettype none
// ============================================================================
//  Module      : life_cell_gen
//  Description : One Generations-family automaton cell. Runtime birth and
//                survive masks, generic neighbour count, optional refractory
//                (dying) states. Only the alive bit is shared with neighbours.
//                Optional feature macro: LIFE_CELL_AGE_EN (alive-age counter).
//  Revision    : 1.0 - initial release
// ============================================================================
module life_cell_gen
    import life_pkg::*;
#(
    parameter int NEIGHBORS   = 8,
    parameter int GENERATIONS = 2,
    parameter int STATE_W     = 4,
    parameter int AGE_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_ena,
    input  logic                   i_load,
    input  logic [STATE_W-1:0]     i_state_0,
    input  logic [NEIGHBORS-1:0]   i_neighbors,
    input  logic [NEIGHBORS:0]     i_birth_mask,
    input  logic [NEIGHBORS:0]     i_survive_mask,
    output logic [STATE_W-1:0]     o_state_d,
    output logic [STATE_W-1:0]     o_state_q,
    output logic                   o_alive,
    output logic [AGE_W-1:0]       o_age
);

    localparam int                 c_CNT_W   = CNT_W(NEIGHBORS);
    localparam logic [STATE_W-1:0] c_DEAD    = STATE_W'(ST_DEAD);
    localparam logic [STATE_W-1:0] c_ALIVE   = STATE_W'(ST_ALIVE);
    localparam logic [STATE_W-1:0] c_FIRST_R = STATE_W'(2);
    localparam logic [STATE_W-1:0] c_LAST    = STATE_W'(GENERATIONS - 1);
    localparam logic [STATE_W:0]   c_GEN     = (STATE_W + 1)'(GENERATIONS);
    localparam bit                 c_CLASSIC = (GENERATIONS == 2);

    logic [STATE_W-1:0] r_state;
    logic [c_CNT_W-1:0] w_count;
    logic [STATE_W-1:0] w_state_d;
    logic [STATE_W-1:0] w_load_val;
    logic [STATE_W-1:0] w_edge_next;

    neighbor_popcount #(.N(NEIGHBORS)) u_popcount (
        .i_bits  (i_neighbors),
        .o_count (w_count)
    );

    // Rule evaluation: next state if this edge were an ena edge
    always_comb begin
        w_state_d = c_DEAD;
        if (r_state == c_DEAD) begin
            w_state_d = i_birth_mask[w_count] ? c_ALIVE : c_DEAD;
        end else if (r_state == c_ALIVE) begin
            if (i_survive_mask[w_count]) begin
                w_state_d = c_ALIVE;
            end else begin
                w_state_d = c_CLASSIC ? c_DEAD : c_FIRST_R;
            end
        end else if (r_state >= c_LAST) begin
            // Last refractory state (and any out-of-range value) decays to dead
            w_state_d = c_DEAD;
        end else begin
            w_state_d = r_state + STATE_W'(1);
        end
    end

    // Loaded values outside the configured state range become dead
    assign w_load_val  = ({1'b0, i_state_0} >= c_GEN) ? c_DEAD : i_state_0;
    assign w_edge_next = i_load ? w_load_val : w_state_d;

    // State register: load has priority over ena, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_DEAD;
        end else if (i_load || i_ena) begin
            r_state <= w_edge_next;
        end
    end

    assign o_state_d = w_state_d;
    assign o_state_q = r_state;
    assign o_alive   = (r_state == c_ALIVE);

`ifdef LIFE_CELL_AGE_EN
    logic [AGE_W-1:0] r_age;

    // Consecutive-alive counter, saturating; restarts on entering state 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_age <= '0;
        end else if (i_load || i_ena) begin
            if (w_edge_next != c_ALIVE) begin
                r_age <= '0;
            end else if (!i_load && (r_state == c_ALIVE)) begin
                if (r_age != {AGE_W{1'b1}}) begin
                    r_age <= r_age + AGE_W'(1);
                end
            end else begin
                r_age <= AGE_W'(1);
            end
        end
    end

    assign o_age = r_age;
`else
    // Port kept so every array site has the same interface
    assign o_age = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_life_cell_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_life_cell_gen
//  Description : Self-checking bench for life_cell_gen. Three instances:
//                A = classic Life (8 nbrs, 2 states), B = 8 nbrs, 4 states,
//                2-bit age, C = von Neumann (4 nbrs, 4 states).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_life_cell_gen;

`ifdef LIFE_CELL_AGE_EN
    localparam bit AGE_ON = 1'b1;
`else
    localparam bit AGE_ON = 1'b0;
`endif

    localparam logic [8:0] BM_CLASSIC = 9'b0_0000_1000;
    localparam logic [8:0] SM_CLASSIC = 9'b0_0000_1100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A
    logic       a_ena, a_load;
    logic [3:0] a_s0, a_sd, a_sq;
    logic [7:0] a_nb, a_age;
    logic [8:0] a_bm, a_sm;
    logic       a_alive;
    // Instance B
    logic       b_ena, b_load;
    logic [3:0] b_s0, b_sd, b_sq;
    logic [7:0] b_nb;
    logic [1:0] b_age;
    logic [8:0] b_bm, b_sm;
    logic       b_alive;
    // Instance C
    logic       c_ena, c_load;
    logic [3:0] c_s0, c_sd, c_sq;
    logic [3:0] c_nb;
    logic [7:0] c_age;
    logic [4:0] c_bm, c_sm;
    logic       c_alive;

    life_cell_gen #(.NEIGHBORS(8), .GENERATIONS(2), .STATE_W(4), .AGE_W(8)) u_a (
        .clk(clk), .rst(rst), .i_ena(a_ena), .i_load(a_load), .i_state_0(a_s0),
        .i_neighbors(a_nb), .i_birth_mask(a_bm), .i_survive_mask(a_sm),
        .o_state_d(a_sd), .o_state_q(a_sq), .o_alive(a_alive), .o_age(a_age));

    life_cell_gen #(.NEIGHBORS(8), .GENERATIONS(4), .STATE_W(4), .AGE_W(2)) u_b (
        .clk(clk), .rst(rst), .i_ena(b_ena), .i_load(b_load), .i_state_0(b_s0),
        .i_neighbors(b_nb), .i_birth_mask(b_bm), .i_survive_mask(b_sm),
        .o_state_d(b_sd), .o_state_q(b_sq), .o_alive(b_alive), .o_age(b_age));

    life_cell_gen #(.NEIGHBORS(4), .GENERATIONS(4), .STATE_W(4), .AGE_W(8)) u_c (
        .clk(clk), .rst(rst), .i_ena(c_ena), .i_load(c_load), .i_state_0(c_s0),
        .i_neighbors(c_nb), .i_birth_mask(c_bm), .i_survive_mask(c_sm),
        .o_state_d(c_sd), .o_state_q(c_sq), .o_alive(c_alive), .o_age(c_age));

    // ---------------- reference model ----------------
    function automatic int m_next(int st, int cnt, logic [24:0] bm, logic [24:0] sm, int g);
        if (st == 0) return bm[cnt] ? 1 : 0;
        if (st == 1) return sm[cnt] ? 1 : ((g == 2) ? 0 : 2);
        if (st + 1 >= g) return 0;
        return st + 1;
    endfunction

    function automatic int m_clamp(int v, int g);
        return (v >= g) ? 0 : v;
    endfunction

    function automatic int m_age(int prev_st, int prev_age, int new_st, bit was_load, int maxv);
        if (!AGE_ON) return 0;
        if (new_st != 1) return 0;
        if (was_load || prev_st != 1) return 1;
        return (prev_age >= maxv) ? maxv : prev_age + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a_ena = 0; a_load = 0; b_ena = 0; b_load = 0; c_ena = 0; c_load = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        a_s0 = 0; a_nb = 0; a_bm = 0; a_sm = 0;
        b_s0 = 0; b_nb = 0; b_bm = 0; b_sm = 0;
        c_s0 = 0; c_nb = 0; c_bm = 0; c_sm = 0;
        tick(); tick();
        n_checks++;
        if (a_sq !== 4'd0 || a_alive !== 1'b0 || a_age !== 8'd0) begin
            n_fail++; $display("FAIL reset_a: sq=%0d alive=%0b age=%0d, expected 0/0/0", a_sq, a_alive, a_age);
        end
        n_checks++;
        if (b_sq !== 4'd0 || b_alive !== 1'b0 || b_age !== 2'd0) begin
            n_fail++; $display("FAIL reset_b: sq=%0d alive=%0b age=%0d, expected 0/0/0", b_sq, b_alive, b_age);
        end
        n_checks++;
        if (c_sq !== 4'd0 || c_alive !== 1'b0 || c_age !== 8'd0) begin
            n_fail++; $display("FAIL reset_c: sq=%0d alive=%0b age=%0d, expected 0/0/0", c_sq, c_alive, c_age);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_classic_survive();
        a_bm = BM_CLASSIC; a_sm = SM_CLASSIC;
        a_load = 1; a_s0 = 4'd1; tick(); a_load = 0;
        n_checks++;
        if (a_sq !== 4'd1 || a_age !== 8'(AGE_ON ? 1 : 0)) begin
            n_fail++; $display("FAIL survive_load: sq=%0d age=%0d, expected 1/%0d", a_sq, a_age, AGE_ON ? 1 : 0);
        end
        a_nb = 8'b0000_0111; a_ena = 1; #1;
        n_checks++;
        if (a_sd !== 4'd1) begin
            n_fail++; $display("FAIL survive_state_d: got %0d, expected 1", a_sd);
        end
        tick(); a_ena = 0;
        n_checks++;
        if (a_sq !== 4'd1 || a_alive !== 1'b1 || a_age !== 8'(AGE_ON ? 2 : 0)) begin
            n_fail++; $display("FAIL survive_step: sq=%0d alive=%0b age=%0d, expected 1/1/%0d", a_sq, a_alive, a_age, AGE_ON ? 2 : 0);
        end
    endtask

    task automatic test_classic_birth_death();
        a_load = 1; a_s0 = 4'd0; tick(); a_load = 0;
        a_nb = 8'b0001_0101; a_ena = 1; tick(); a_ena = 0;
        n_checks++;
        if (a_sq !== 4'd1 || a_alive !== 1'b1 || a_age !== 8'(AGE_ON ? 1 : 0)) begin
            n_fail++; $display("FAIL birth: sq=%0d alive=%0b age=%0d, expected 1/1/%0d", a_sq, a_alive, a_age, AGE_ON ? 1 : 0);
        end
        a_nb = 8'b1111_0000; a_ena = 1; tick(); a_ena = 0;
        n_checks++;
        if (a_sq !== 4'd0 || a_alive !== 1'b0 || a_age !== 8'd0) begin
            n_fail++; $display("FAIL overcrowd: sq=%0d alive=%0b age=%0d, expected 0/0/0", a_sq, a_alive, a_age);
        end
    endtask

    task automatic test_refractory();
        int exp_st[4] = '{2, 3, 0, 0};
        b_bm = 0; b_sm = 0; b_nb = 8'hFF;
        b_load = 1; b_s0 = 4'd1; tick(); b_load = 0;
        n_checks++;
        if (b_sq !== 4'd1 || b_alive !== 1'b1) begin
            n_fail++; $display("FAIL refr_start: sq=%0d alive=%0b, expected 1/1", b_sq, b_alive);
        end
        for (int i = 0; i < 4; i++) begin
            b_ena = 1; tick(); b_ena = 0;
            n_checks++;
            if (b_sq !== 4'(exp_st[i]) || b_alive !== 1'b0) begin
                n_fail++; $display("FAIL refr_step%0d: sq=%0d alive=%0b, expected %0d/0", i, b_sq, b_alive, exp_st[i]);
            end
        end
    endtask

    task automatic test_von_neumann();
        c_load = 1; c_s0 = 4'd0; tick(); c_load = 0;
        c_bm = 5'b10000; c_sm = 5'b00000; c_nb = 4'hF; c_ena = 1; tick(); c_ena = 0;
        n_checks++;
        if (c_sq !== 4'd1 || c_alive !== 1'b1) begin
            n_fail++; $display("FAIL vn_birth4: sq=%0d alive=%0b, expected 1/1", c_sq, c_alive);
        end
        c_load = 1; c_s0 = 4'd0; tick(); c_load = 0;
        c_nb = 4'h7; c_ena = 1; tick(); c_ena = 0;
        n_checks++;
        if (c_sq !== 4'd0) begin
            n_fail++; $display("FAIL vn_nobirth3: sq=%0d, expected 0", c_sq);
        end
    endtask

    task automatic test_load_priority();
        a_bm = BM_CLASSIC; a_sm = SM_CLASSIC;
        a_load = 1; a_s0 = 4'd0; tick();
        a_s0 = 4'd1; a_ena = 1; a_nb = 8'h00; tick(); a_load = 0; a_ena = 0;
        n_checks++;
        if (a_sq !== 4'd1) begin
            n_fail++; $display("FAIL load_over_ena: sq=%0d, expected 1", a_sq);
        end
        b_load = 1; b_s0 = 4'hF; tick();
        n_checks++;
        if (b_sq !== 4'd0) begin
            n_fail++; $display("FAIL load_clamp: sq=%0d, expected 0", b_sq);
        end
        b_s0 = 4'd2; tick(); b_load = 0;
        n_checks++;
        if (b_sq !== 4'd2 || b_alive !== 1'b0) begin
            n_fail++; $display("FAIL load_refr: sq=%0d alive=%0b, expected 2/0", b_sq, b_alive);
        end
    endtask

    task automatic test_async_reset();
        // A is alive from the previous test; pulse rst between clock edges
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (a_sq !== 4'd0 || a_alive !== 1'b0 || a_age !== 8'd0) begin
            n_fail++; $display("FAIL async_reset: sq=%0d alive=%0b age=%0d, expected 0/0/0", a_sq, a_alive, a_age);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_age_saturate();
        int exp_age[5] = '{2, 3, 3, 3, 3};
        b_sm = 9'h1FF; b_nb = 8'h5A;
        b_load = 1; b_s0 = 4'd1; tick(); b_load = 0;
        for (int i = 0; i < 5; i++) begin
            b_ena = 1; tick(); b_ena = 0;
            n_checks++;
            if (b_sq !== 4'd1 || b_age !== 2'(AGE_ON ? exp_age[i] : 0)) begin
                n_fail++; $display("FAIL age_sat%0d: sq=%0d age=%0d, expected 1/%0d", i, b_sq, b_age, AGE_ON ? exp_age[i] : 0);
            end
        end
    endtask

    task automatic test_random();
        int ma, mb, aa, ab, na, nb;
        // Start the model from a known reset state
        #1 rst = 1'b1; #1 rst = 1'b0;
        ma = 0; mb = 0; aa = 0; ab = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            a_load = ($urandom_range(0, 7) == 0); a_ena = $urandom_range(0, 1);
            a_s0 = 4'($urandom); a_nb = 8'($urandom);
            a_bm = 9'($urandom); a_sm = 9'($urandom);
            b_load = ($urandom_range(0, 7) == 0); b_ena = $urandom_range(0, 1);
            b_s0 = 4'($urandom); b_nb = 8'($urandom);
            b_bm = 9'($urandom); b_sm = 9'($urandom);
            #1;
            na = m_next(ma, $countones(a_nb), 25'(a_bm), 25'(a_sm), 2);
            nb = m_next(mb, $countones(b_nb), 25'(b_bm), 25'(b_sm), 4);
            n_checks++;
            if (a_sd !== 4'(na) || b_sd !== 4'(nb)) begin
                n_fail++; $display("FAIL rand_state_d cyc%0d: a=%0d b=%0d, expected %0d/%0d", cyc, a_sd, b_sd, na, nb);
            end
            if (a_load) begin
                na = m_clamp(int'(a_s0), 2); aa = m_age(ma, aa, na, 1'b1, 255); ma = na;
            end else if (a_ena) begin
                aa = m_age(ma, aa, na, 1'b0, 255); ma = na;
            end
            if (b_load) begin
                nb = m_clamp(int'(b_s0), 4); ab = m_age(mb, ab, nb, 1'b1, 3); mb = nb;
            end else if (b_ena) begin
                ab = m_age(mb, ab, nb, 1'b0, 3); mb = nb;
            end
            tick();
            idle_all();
            n_checks++;
            if (a_sq !== 4'(ma) || a_alive !== (ma == 1) || a_age !== 8'(aa)) begin
                n_fail++; $display("FAIL rand_a cyc%0d: sq=%0d alive=%0b age=%0d, expected %0d/%0b/%0d", cyc, a_sq, a_alive, a_age, ma, ma == 1, aa);
            end
            n_checks++;
            if (b_sq !== 4'(mb) || b_alive !== (mb == 1) || b_age !== 2'(ab)) begin
                n_fail++; $display("FAIL rand_b cyc%0d: sq=%0d alive=%0b age=%0d, expected %0d/%0b/%0d", cyc, b_sq, b_alive, b_age, mb, mb == 1, ab);
            end
        end
    endtask

    initial begin
        test_reset();
        test_classic_survive();
        test_classic_birth_death();
        test_refractory();
        test_von_neumann();
        test_load_priority();
        test_async_reset();
        test_age_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
